// File: rtl/aclk_pkg.sv
// Shared definitions for the alarm-clock keypad controller: key codes, state enum, digit test.
package aclk_pkg;

   localparam logic [3:0] KEY_ALARM = 4'hA;
   localparam logic [3:0] KEY_TIME  = 4'hB;

   typedef enum logic [2:0] {
      SHOW_TIME  = 3'd0,
      ENTRY      = 3'd1,
      SHOW_ALARM = 3'd2,
      LOAD_ALARM = 3'd3,
      LOAD_TIME  = 3'd4
   } aclk_state_t;

   function automatic logic is_digit(input logic [3:0] code);
      return (code <= 4'd9);
   endfunction

endpackage

// File: rtl/aclk_sec_timer.sv
// Clearable, saturating one_second counter with a terminal-count compare against i_limit.
module aclk_sec_timer #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         i_clear,
   input  logic         i_enable,
   input  logic         i_tick,
   input  logic [W-1:0] i_limit,
   output logic         o_tc
);

   localparam logic [W-1:0] CNT_MAX = {W{1'b1}};

   logic [W-1:0] r_cnt;

   // Second counter: clear wins over increment, saturates at all-ones.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt <= {W{1'b0}};
      end else if (i_clear) begin
         r_cnt <= {W{1'b0}};
      end else if (i_enable && i_tick && (r_cnt != CNT_MAX)) begin
         r_cnt <= r_cnt + W'(1);
      end else begin
         r_cnt <= r_cnt;
      end
   end

   // Fires on the tick that would bring the count up to the limit.
   assign o_tc = i_enable && i_tick && (r_cnt == (i_limit - W'(1)));

endmodule

// File: rtl/aclk_ctrl_fsm.sv
// Keypad control FSM for the alarm clock; all outputs registered.
// Optional idle/display timeouts are built when ACLK_TIMEOUT_EN is defined.
module aclk_ctrl_fsm
   import aclk_pkg::*;
#(
   parameter int TIMEOUT_SEC    = 10,
   parameter int SHOW_ALARM_SEC = 5,
   parameter int NUM_DIGITS     = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       key_valid,
   input  logic [3:0] key_code,
   input  logic       one_second,
   output logic       shift,
   output logic       clear_entry,
   output logic       show_new_time,
   output logic       show_a,
   output logic       load_new_a,
   output logic       load_new_c,
   output logic       reset_count,
   output logic [2:0] digit_cnt
);

   localparam logic [2:0] DIG_MAX = 3'(NUM_DIGITS);

   aclk_state_t r_state, w_next_state;
   logic [2:0]  r_digit_cnt, w_digit_cnt;
   logic        r_shift, r_clear, r_show_new, r_show_a, r_load_a, r_load_c;
   logic        w_shift, w_clear, w_digit_clr;
   logic        w_key_dig, w_key_alarm, w_key_time, w_key_any;
   logic        w_tc;

   assign w_key_dig   = key_valid && is_digit(key_code);
   assign w_key_alarm = key_valid && (key_code == KEY_ALARM);
   assign w_key_time  = key_valid && (key_code == KEY_TIME);
   assign w_key_any   = w_key_dig || w_key_alarm || w_key_time;

`ifdef ACLK_TIMEOUT_EN
   localparam int SEC_MAX = (TIMEOUT_SEC > SHOW_ALARM_SEC) ? TIMEOUT_SEC : SHOW_ALARM_SEC;
   localparam int SEC_W   = $clog2(SEC_MAX + 1);

   logic [SEC_W-1:0] w_limit;
   logic             w_timer_en, w_timer_clr;

   assign w_limit     = (r_state == SHOW_ALARM) ? SEC_W'(SHOW_ALARM_SEC) : SEC_W'(TIMEOUT_SEC);
   assign w_timer_en  = (r_state == ENTRY) || (r_state == SHOW_ALARM);
   // Any state change restarts the count, as does every digit typed in ENTRY.
   assign w_timer_clr = (w_next_state != r_state) || w_digit_clr;

   aclk_sec_timer #(.W(SEC_W)) u_sec_timer (
      .clk      (clk),
      .reset    (reset),
      .i_clear  (w_timer_clr),
      .i_enable (w_timer_en),
      .i_tick   (one_second),
      .i_limit  (w_limit),
      .o_tc     (w_tc)
   );
`else
   logic w_unused_sec;
   assign w_unused_sec = one_second;
   assign w_tc         = 1'b0;
`endif

   // Next-state and next-output decode; keys always take priority over the timeout.
   always_comb begin
      w_next_state = r_state;
      w_digit_cnt  = r_digit_cnt;
      w_shift      = 1'b0;
      w_clear      = 1'b0;
      w_digit_clr  = 1'b0;
      case (r_state)
         SHOW_TIME: begin
            if (w_key_dig) begin
               w_next_state = ENTRY;
               w_shift      = 1'b1;
               w_digit_cnt  = 3'd1;
            end else if (w_key_alarm) begin
               w_next_state = SHOW_ALARM;
            end else begin
               w_next_state = SHOW_TIME;
            end
         end
         ENTRY: begin
            if (w_key_dig) begin
               w_digit_clr = 1'b1;
               if (r_digit_cnt < DIG_MAX) begin
                  w_shift     = 1'b1;
                  w_digit_cnt = r_digit_cnt + 3'd1;
               end else begin
                  w_digit_cnt = r_digit_cnt;
               end
            end else if (w_key_alarm || w_key_time) begin
               if (r_digit_cnt == DIG_MAX) begin
                  w_next_state = w_key_alarm ? LOAD_ALARM : LOAD_TIME;
               end else begin
                  w_next_state = SHOW_TIME;
                  w_clear      = 1'b1;
                  w_digit_cnt  = 3'd0;
               end
            end else if (w_tc) begin
               w_next_state = SHOW_TIME;
               w_clear      = 1'b1;
               w_digit_cnt  = 3'd0;
            end else begin
               w_next_state = ENTRY;
            end
         end
         SHOW_ALARM: begin
            if (w_key_any || w_tc) begin
               w_next_state = SHOW_TIME;
            end else begin
               w_next_state = SHOW_ALARM;
            end
         end
         LOAD_ALARM, LOAD_TIME: begin
            w_next_state = SHOW_TIME;
            w_digit_cnt  = 3'd0;
         end
         default: begin
            w_next_state = SHOW_TIME;
            w_digit_cnt  = 3'd0;
         end
      endcase
   end

   // State and registered outputs; load strobes and display levels follow the state being entered.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= SHOW_TIME;
         r_digit_cnt <= 3'd0;
         r_shift     <= 1'b0;
         r_clear     <= 1'b0;
         r_show_new  <= 1'b0;
         r_show_a    <= 1'b0;
         r_load_a    <= 1'b0;
         r_load_c    <= 1'b0;
      end else begin
         r_state     <= w_next_state;
         r_digit_cnt <= w_digit_cnt;
         r_shift     <= w_shift;
         r_clear     <= w_clear;
         r_show_new  <= (w_next_state == ENTRY);
         r_show_a    <= (w_next_state == SHOW_ALARM);
         r_load_a    <= (w_next_state == LOAD_ALARM);
         r_load_c    <= (w_next_state == LOAD_TIME);
      end
   end

   assign shift         = r_shift;
   assign clear_entry   = r_clear;
   assign show_new_time = r_show_new;
   assign show_a        = r_show_a;
   assign load_new_a    = r_load_a;
   assign load_new_c    = r_load_c;
   assign reset_count   = r_load_c;
   assign digit_cnt     = r_digit_cnt;

endmodule
